// File: rtl/mem_loader.sv
// mem_loader: streams an image byte stream into main memory as big-endian
// words, one word per memory write, while holding the CPU off the bus.
//
// Ports
//   MEM_LOADER_CLOCK_50         system clock, rising edge
//   MEM_LOADER_ResetInHigh_In   asynchronous active-high reset
//   MEM_LOADER_Start_In         start-load pulse (honoured in IDLE/DONE/ERROR)
//   MEM_LOADER_Byte_InBus       image byte, qualified by ByteValid
//   MEM_LOADER_ByteValid_In     byte valid
//   MEM_LOADER_ByteReady_Out    byte accepted when Valid and Ready are high
//   MEM_LOADER_A_OutBus         memory address
//   MEM_LOADER_B_OutBus         memory write data
//   MEM_LOADER_RD_Out           read strobe (read-back only)
//   MEM_LOADER_WRMain_Out       write strobe
//   MEM_LOADER_ACK_In           memory acknowledge
//   MEM_LOADER_Data_InBus       memory read data (read-back only)
//   MEM_LOADER_Busy_Out / Done_Out / Error_Out / HoldCPU_Out  status
//
// Build option: define MEM_LOADER_VERIFY_EN to read each word back after
// writing it and flag ERROR on a mismatch.
module mem_loader #(
    parameter int          DATAWIDTH_BUS  = 32,
    parameter int          LOAD_WORDS     = 64,
    parameter logic [31:0] BASE_ADDRESS   = 32'h0,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                     MEM_LOADER_CLOCK_50,
    input  logic                     MEM_LOADER_ResetInHigh_In,
    input  logic                     MEM_LOADER_Start_In,
    input  logic [7:0]               MEM_LOADER_Byte_InBus,
    input  logic                     MEM_LOADER_ByteValid_In,
    output logic                     MEM_LOADER_ByteReady_Out,
    output logic [DATAWIDTH_BUS-1:0] MEM_LOADER_A_OutBus,
    output logic [DATAWIDTH_BUS-1:0] MEM_LOADER_B_OutBus,
    output logic                     MEM_LOADER_RD_Out,
    output logic                     MEM_LOADER_WRMain_Out,
    input  logic                     MEM_LOADER_ACK_In,
    input  logic [DATAWIDTH_BUS-1:0] MEM_LOADER_Data_InBus,
    output logic                     MEM_LOADER_Busy_Out,
    output logic                     MEM_LOADER_Done_Out,
    output logic                     MEM_LOADER_Error_Out,
    output logic                     MEM_LOADER_HoldCPU_Out
);

    localparam int IDXW = $clog2(LOAD_WORDS + 1);
    localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, COLLECT, WRITE, NEXT, DONE, ERROR
`ifdef MEM_LOADER_VERIFY_EN
        , READ
`endif
    } state_t;

    state_t state, next_state;

    logic [31:0]              word;
    logic [1:0]               byte_cnt;
    logic [IDXW-1:0]          word_idx;
    logic [IDXW-1:0]          idx_inc;
    logic [TW-1:0]            wait_cnt;
    logic                     start_ok;
    logic                     timeout;
    logic                     in_access;
    logic [DATAWIDTH_BUS-1:0] addr;

    assign start_ok = MEM_LOADER_Start_In &&
                      (state == IDLE || state == DONE || state == ERROR);
    assign idx_inc  = word_idx + IDXW'(1);
    assign timeout  = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
    // Address arithmetic wraps at the bus width.
    assign addr     = DATAWIDTH_BUS'(BASE_ADDRESS) +
                      DATAWIDTH_BUS'({word_idx, 2'b00});

`ifdef MEM_LOADER_VERIFY_EN
    assign in_access = (state == WRITE) || (state == READ);
`else
    assign in_access = (state == WRITE);
    logic [DATAWIDTH_BUS-1:0] unused_data;
    assign unused_data = MEM_LOADER_Data_InBus;
`endif

    // State register; reset drops the strobes with no clock edge because
    // both strobes decode straight from state.
    always_ff @(posedge MEM_LOADER_CLOCK_50 or posedge MEM_LOADER_ResetInHigh_In) begin
        if (MEM_LOADER_ResetInHigh_In) state <= IDLE;
        else                           state <= next_state;
    end

    // Next-state logic. ACK wins over a timeout on the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERROR: if (start_ok) next_state = COLLECT;
            COLLECT: if (MEM_LOADER_ByteValid_In && byte_cnt == 2'd3)
                         next_state = WRITE;
            WRITE: begin
                if (MEM_LOADER_ACK_In)
`ifdef MEM_LOADER_VERIFY_EN
                    next_state = READ;
`else
                    next_state = NEXT;
`endif
                else if (timeout)
                    next_state = ERROR;
            end
`ifdef MEM_LOADER_VERIFY_EN
            READ: begin
                if (MEM_LOADER_ACK_In)
                    next_state = (MEM_LOADER_Data_InBus == DATAWIDTH_BUS'(word)) ? NEXT : ERROR;
                else if (timeout)
                    next_state = ERROR;
            end
`endif
            NEXT: next_state = (idx_inc == IDXW'(LOAD_WORDS)) ? DONE : COLLECT;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: word assembly, byte/word counters, ACK wait counter.
    always_ff @(posedge MEM_LOADER_CLOCK_50 or posedge MEM_LOADER_ResetInHigh_In) begin
        if (MEM_LOADER_ResetInHigh_In) begin
            word     <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
            wait_cnt <= '0;
        end else begin
            if (start_ok) begin
                word_idx <= '0;
                byte_cnt <= '0;
            end
            // First byte ends up in 31:24 after four shifts.
            if (state == COLLECT && MEM_LOADER_ByteValid_In) begin
                word     <= {word[23:0], MEM_LOADER_Byte_InBus};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == NEXT)
                word_idx <= idx_inc;
            // Counter restarts whenever a new access state is entered.
            if (in_access && next_state == state)
                wait_cnt <= wait_cnt + TW'(1);
            else
                wait_cnt <= '0;
        end
    end

    // Outputs decode from state only.
    always_comb begin
        MEM_LOADER_ByteReady_Out = (state == COLLECT);
        MEM_LOADER_WRMain_Out    = (state == WRITE);
`ifdef MEM_LOADER_VERIFY_EN
        MEM_LOADER_RD_Out        = (state == READ);
`else
        MEM_LOADER_RD_Out        = 1'b0;
`endif
        MEM_LOADER_A_OutBus      = in_access ? addr : '0;
        MEM_LOADER_B_OutBus      = in_access ? DATAWIDTH_BUS'(word) : '0;
        MEM_LOADER_Busy_Out      = (state == COLLECT) || in_access || (state == NEXT);
        MEM_LOADER_Done_Out      = (state == DONE);
        MEM_LOADER_Error_Out     = (state == ERROR);
        MEM_LOADER_HoldCPU_Out   = (state != DONE);
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader. Two instances share all inputs:
// dut0 (base 0) and dut1 (base 0xFFFFFFFC, checks address wrap).
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        valid = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'h0;

    logic        rdy0, rd0, wr0, busy0, done0, err0, hold0;
    logic [31:0] a0, b0;
    logic        rdy1, rd1, wr1, busy1, done1, err1, hold1;
    logic [31:0] a1, b1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_loader #(.DATAWIDTH_BUS(32), .LOAD_WORDS(2), .BASE_ADDRESS(32'h0),
                 .TIMEOUT_CYCLES(8)) dut0 (
        .MEM_LOADER_CLOCK_50(clk), .MEM_LOADER_ResetInHigh_In(rst),
        .MEM_LOADER_Start_In(start), .MEM_LOADER_Byte_InBus(byte_in),
        .MEM_LOADER_ByteValid_In(valid), .MEM_LOADER_ByteReady_Out(rdy0),
        .MEM_LOADER_A_OutBus(a0), .MEM_LOADER_B_OutBus(b0),
        .MEM_LOADER_RD_Out(rd0), .MEM_LOADER_WRMain_Out(wr0),
        .MEM_LOADER_ACK_In(ack), .MEM_LOADER_Data_InBus(rdata),
        .MEM_LOADER_Busy_Out(busy0), .MEM_LOADER_Done_Out(done0),
        .MEM_LOADER_Error_Out(err0), .MEM_LOADER_HoldCPU_Out(hold0));

    mem_loader #(.DATAWIDTH_BUS(32), .LOAD_WORDS(2), .BASE_ADDRESS(32'hFFFF_FFFC),
                 .TIMEOUT_CYCLES(8)) dut1 (
        .MEM_LOADER_CLOCK_50(clk), .MEM_LOADER_ResetInHigh_In(rst),
        .MEM_LOADER_Start_In(start), .MEM_LOADER_Byte_InBus(byte_in),
        .MEM_LOADER_ByteValid_In(valid), .MEM_LOADER_ByteReady_Out(rdy1),
        .MEM_LOADER_A_OutBus(a1), .MEM_LOADER_B_OutBus(b1),
        .MEM_LOADER_RD_Out(rd1), .MEM_LOADER_WRMain_Out(wr1),
        .MEM_LOADER_ACK_In(ack), .MEM_LOADER_Data_InBus(rdata),
        .MEM_LOADER_Busy_Out(busy1), .MEM_LOADER_Done_Out(done1),
        .MEM_LOADER_Error_Out(err1), .MEM_LOADER_HoldCPU_Out(hold1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge in COLLECT; returns at the negedge of the first
    // WRITE cycle. mid_start pulses Start alongside the third byte.
    task automatic send_word(input logic [31:0] w, input bit mid_start);
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            while (!rdy0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!rdy0) check("rdy_wait", {31'h0, rdy0}, 32'h1);
            byte_in = w[31-8*i -: 8];
            valid   = 1'b1;
            start   = mid_start && (i == 2);
            @(negedge clk);
        end
        valid = 1'b0;
        start = 1'b0;
    endtask

    // Called at the negedge of the first WRITE cycle; ACK arrives in the
    // d-th WRITE cycle. Returns at the negedge after the last ACK.
    task automatic do_write(input string tag, input logic [31:0] ea0, input logic [31:0] ea1,
                            input logic [31:0] w, input int d, input logic [31:0] rb);
        check({tag, ".wr"}, {31'h0, wr0}, 32'h1);
        check({tag, ".rd"}, {31'h0, rd0}, 32'h0);
        check({tag, ".a0"}, a0, ea0);
        check({tag, ".b0"}, b0, w);
        check({tag, ".a1"}, a1, ea1);
        check({tag, ".rdy"}, {31'h0, rdy0}, 32'h0);
        for (int k = 1; k < d; k++) begin
            @(negedge clk);
            check({tag, ".wr_hold"}, {31'h0, wr0}, 32'h1);
            check({tag, ".a_hold"}, a0, ea0);
            check({tag, ".b_hold"}, b0, w);
            check({tag, ".rdy_hold"}, {31'h0, rdy0}, 32'h0);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check({tag, ".wr_drop"}, {31'h0, wr0}, 32'h0);
`ifdef MEM_LOADER_VERIFY_EN
        check({tag, ".rd_on"}, {31'h0, rd0}, 32'h1);
        check({tag, ".rd_a"}, a0, ea0);
        rdata = rb;
        ack   = 1'b1;
        @(negedge clk);
        ack   = 1'b0;
        check({tag, ".rd_drop"}, {31'h0, rd0}, 32'h0);
`else
        check({tag, ".rd_tied"}, {31'h0, rd0}, 32'h0);
        rdata = rb;
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        check("rst.wr", {31'h0, wr0}, 32'h0);
        check("rst.rd", {31'h0, rd0}, 32'h0);
        check("rst.a", a0, 32'h0);
        check("rst.b", b0, 32'h0);
        check("rst.rdy", {31'h0, rdy0}, 32'h0);
        check("rst.status", {28'h0, busy0, done0, err0, hold0}, 32'h1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle.status", {27'h0, rdy0, busy0, done0, err0, hold0}, 32'h1);

        // Two-word load, 1-cycle ACK; also dut1 address wrap
        pulse_start();
        check("col.rdy", {31'h0, rdy0}, 32'h1);
        check("col.busy", {31'h0, busy0}, 32'h1);
        ack = 1'b1;               // ACK with strobes low is ignored
        @(negedge clk);
        ack = 1'b0;
        check("stray_ack", {30'h0, rdy0, wr0}, 32'h2);
        send_word(32'h1234_5678, 1'b0);
        do_write("w0", 32'h0, 32'hFFFF_FFFC, 32'h1234_5678, 1, 32'h1234_5678);
        check("next.status", {29'h0, rdy0, busy0, done0}, 32'h2);
        @(negedge clk);
        check("next.collect", {31'h0, rdy0}, 32'h1);
        send_word(32'h9ABC_DEF0, 1'b1);  // Start mid-word must be ignored
        do_write("w1", 32'h4, 32'h0, 32'h9ABC_DEF0, 1, 32'h9ABC_DEF0);
        @(negedge clk);
        check("done.done", {31'h0, done0}, 32'h1);
        check("done.hold", {31'h0, hold0}, 32'h0);
        check("done.busy", {31'h0, busy0}, 32'h0);
        check("done1.done", {31'h0, done1}, 32'h1);

        // Delayed ACK (5 cycles)
        pulse_start();
        check("dly.done_clr", {31'h0, done0}, 32'h0);
        send_word(32'hCAFE_F00D, 1'b0);
        do_write("dly", 32'h0, 32'hFFFF_FFFC, 32'hCAFE_F00D, 5, 32'hCAFE_F00D);
        @(negedge clk);
        send_word(32'h0102_0304, 1'b0);
        do_write("dly2", 32'h4, 32'h0, 32'h0102_0304, 1, 32'h0102_0304);
        @(negedge clk);
        check("dly.done", {31'h0, done0}, 32'h1);

        // Timeout: no ACK for 8 WRITE cycles
        pulse_start();
        send_word(32'h55AA_55AA, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("tmo.wr", {31'h0, wr0}, 32'h1);
            @(negedge clk);
        end
        check("tmo.err", {31'h0, err0}, 32'h1);
        check("tmo.wr_low", {31'h0, wr0}, 32'h0);
        check("tmo.hold", {31'h0, hold0}, 32'h1);
        check("tmo.busy", {31'h0, busy0}, 32'h0);

        // Reset during WRITE drops the strobe without a clock edge
        pulse_start();
        check("err.clr", {31'h0, err0}, 32'h0);
        send_word(32'hDEAD_BEEF, 1'b0);
        check("rstw.wr_before", {31'h0, wr0}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rstw.wr0", {31'h0, wr0}, 32'h0);
        check("rstw.wr1", {31'h0, wr1}, 32'h0);
        check("rstw.a", a0, 32'h0);
        check("rstw.hold", {31'h0, hold0}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        send_word(32'h1122_3344, 1'b0);
        do_write("rld", 32'h0, 32'hFFFF_FFFC, 32'h1122_3344, 1, 32'h1122_3344);

`ifdef MEM_LOADER_VERIFY_EN
        // Read-back mismatch
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        send_word(32'h1234_5678, 1'b0);
        do_write("vfy", 32'h0, 32'hFFFF_FFFC, 32'h1234_5678, 1, 32'h1234_5679);
        check("vfy.err", {31'h0, err0}, 32'h1);
        check("vfy.done", {31'h0, done0}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
